// File: rtl/pwm_pulse_capture_if.sv
// Signal bundle between the PWM capture front end and its host/consumer.
// The master side drives enable and the raw pin; the slave (capture block) returns measurements.
interface pwm_pulse_capture_if #(
  parameter int CW = 15
);
  logic          en;
  logic          pwm_in;
  logic [CW-1:0] width_o;
  logic          width_vld_o;
  logic [1:0]    level_o;
  logic          ovf_o;
  logic          timeout_o;

  modport master (
    output en, pwm_in,
    input  width_o, width_vld_o, level_o, ovf_o, timeout_o
  );

  modport slave (
    input  en, pwm_in,
    output width_o, width_vld_o, level_o, ovf_o, timeout_o
  );
endinterface

// File: rtl/pwm_pulse_capture.sv
// PWM front end: synchronise and glitch-filter the pin, measure high pulses in ticks,
// classify LOW/MID/HIGH and flag loss of signal.
//
// state | meaning
// IDLE  | disabled, or waiting for a settled low level before arming
// ARMED | waiting for a filtered rising edge
// MEAS  | counting the high time of the current pulse
module pwm_pulse_capture #(
  parameter int MAX_COUNTER_VALUE  = 2000,
  parameter int HIGH_COUNTER_VALUE = 1900,
  parameter int LOW_COUNTER_VALUE  = 1100,
  parameter int FILTER_LEN         = 3,
  parameter int TIMEOUT_VALUE      = 25000,
  parameter int CW                 = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  pwm_pulse_capture_if.slave   bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  localparam logic [1:0]    LVL_LOW  = 2'b00;
  localparam logic [1:0]    LVL_MID  = 2'b01;
  localparam logic [1:0]    LVL_HIGH = 2'b10;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_COUNTER_VALUE);
  localparam logic [CW-1:0] CNT_HIGH = CW'(HIGH_COUNTER_VALUE);
  localparam logic [CW-1:0] CNT_LOW  = CW'(LOW_COUNTER_VALUE);
  localparam logic [CW-1:0] TO_MAX   = CW'(TIMEOUT_VALUE);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_VALUE - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_MEAS  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_f;
  logic [FW-1:0] r_fcnt;
  logic          r_settled;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_tcnt;
  logic [CW-1:0] r_width;
  logic          r_vld;
  logic [1:0]    r_level;
  logic          r_ovf;
  logic          r_timeout;

  logic          w_f_nxt;
  logic [FW-1:0] w_fcnt_nxt;
  logic          w_rise;
  logic          w_fall;
  logic          w_strobe;
  logic          w_to_set;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_tcnt_nxt;
  logic [CW-1:0] w_tcnt_inc;
  logic [1:0]    w_level;
  logic          w_arm_ok;

  // Filter toggles after FILTER_LEN consecutive differing samples; the FSM acts on
  // the toggle itself so both edges see the same pin-to-decision latency.
  always_comb begin
    w_f_nxt    = r_f;
    w_fcnt_nxt = '0;
    if (r_sync2 != r_f) begin
      if (r_fcnt == FLT_LAST) begin
        w_f_nxt = ~r_f;
      end else begin
        w_fcnt_nxt = r_fcnt + 1'b1;
      end
    end
  end

  assign w_rise     = ~r_f & w_f_nxt;
  assign w_fall     = r_f & ~w_f_nxt;
  assign w_tcnt_inc = (r_tcnt == TO_MAX) ? r_tcnt : r_tcnt + 1'b1;
  // Arm only once the whole input path is quiet low, so a pulse in flight at
  // enable or reset release is never measured.
  assign w_arm_ok   = r_settled & ~r_sync1 & ~r_sync2 & ~r_f & (r_fcnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_strobe    = 1'b0;
    w_to_set    = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_tcnt_nxt  = r_tcnt;
    if (!bus.en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_tcnt_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt  = '0;
          w_tcnt_nxt = '0;
          if (w_arm_ok) begin
            w_state_nxt = S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_rise) begin
            w_state_nxt = S_MEAS;
            w_cnt_nxt   = CW'(1);
            w_tcnt_nxt  = '0;
          end else begin
            w_tcnt_nxt = w_tcnt_inc;
            w_to_set   = (r_tcnt == TO_LAST);
          end
        end
        S_MEAS: begin
          w_tcnt_nxt = w_tcnt_inc;
          w_to_set   = (r_tcnt == TO_LAST);
          if (w_fall) begin
            w_state_nxt = S_ARMED;
            w_strobe    = 1'b1;
          end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_tcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_level = LVL_MID;
    if (r_cnt > CNT_HIGH) begin
      w_level = LVL_HIGH;
    end else if (r_cnt < CNT_LOW) begin
      w_level = LVL_LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_f       <= 1'b0;
      r_fcnt    <= '0;
      r_settled <= 1'b0;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_width   <= '0;
      r_vld     <= 1'b0;
      r_level   <= LVL_LOW;
      r_ovf     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sync1   <= bus.pwm_in;
      r_sync2   <= r_sync1;
      r_f       <= w_f_nxt;
      r_fcnt    <= w_fcnt_nxt;
      r_settled <= 1'b1;
      r_cnt     <= w_cnt_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_vld     <= w_strobe;
      if (w_strobe) begin
        r_width <= r_cnt;
        r_level <= w_level;
        r_ovf   <= (r_cnt == CNT_MAX);
      end
      // A measurement completing in the timeout cycle takes precedence.
      if (!bus.en || w_strobe) begin
        r_timeout <= 1'b0;
      end else if (w_to_set) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.width_o     = r_width;
  assign bus.width_vld_o = r_vld;
  assign bus.level_o     = r_level;
  assign bus.ovf_o       = r_ovf;
  assign bus.timeout_o   = r_timeout;

endmodule

// File: tb/tb_pwm_pulse_capture.sv
// Directed bench for pwm_pulse_capture: width, class, overflow, timeout, filtering,
// enable and reset behaviour against hand-computed values.
`timescale 1ns/1ps
module tb_pwm_pulse_capture;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   strobe_cnt;
  int   consec_cnt;
  logic prev_vld;

  pwm_pulse_capture_if #(.CW(15)) bus ();

  pwm_pulse_capture dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  initial begin
    strobe_cnt = 0;
    consec_cnt = 0;
    prev_vld   = 1'b0;
  end

  always @(negedge clk) begin
    if (bus.width_vld_o === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      if (prev_vld) consec_cnt = consec_cnt + 1;
    end
    prev_vld = (bus.width_vld_o === 1'b1);
  end

  // Drive one high pulse of n ticks and report how many cycles after the pin fell
  // the strobe appeared (0 if it never did within the bound).
  task automatic run_pulse(input int n, output bit seen, output int lat);
    @(negedge clk);
    bus.pwm_in = 1'b1;
    repeat (n) @(negedge clk);
    bus.pwm_in = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!seen && bus.width_vld_o === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.pwm_in = 1'b0;
    repeat (200) @(negedge clk);
    n_tests++; if (bus.width_o !== 15'd0) begin n_fail++; $display("FAIL reset_width: got %0d expected 0", bus.width_o); end
    n_tests++; if (bus.width_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", bus.width_vld_o); end
    n_tests++; if (bus.level_o !== 2'b00) begin n_fail++; $display("FAIL reset_level: got %b expected 00", bus.level_o); end
    n_tests++; if (bus.ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf_o); end
    n_tests++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout_o); end
    rst = 1'b0;
    bus.en = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic;
    bit seen;
    int lat;
    run_pulse(1500, seen, lat);
    n_tests++; if (!seen) begin n_fail++; $display("FAIL basic_strobe: got none expected one within 20 cycles"); end
    n_tests++; if (lat != 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    n_tests++; if (bus.width_o !== 15'd1500) begin n_fail++; $display("FAIL basic_width: got %0d expected 1500", bus.width_o); end
    n_tests++; if (bus.level_o !== 2'b01) begin n_fail++; $display("FAIL basic_level: got %b expected 01", bus.level_o); end
    n_tests++; if (bus.ovf_o !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b expected 0", bus.ovf_o); end
  endtask

  task automatic test_levels;
    int         widths [6] = '{1000, 1099, 1100, 1900, 1901, 1950};
    logic [1:0] levels [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
    bit seen;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_pulse(widths[i], seen, lat);
      n_tests++; if (!seen || bus.width_o !== 15'(widths[i])) begin n_fail++; $display("FAIL level_width[%0d]: got %0d seen=%0d expected %0d", i, bus.width_o, seen, widths[i]); end
      n_tests++; if (bus.level_o !== levels[i]) begin n_fail++; $display("FAIL level_class[%0d]: got %b expected %b", i, bus.level_o, levels[i]); end
    end
  endtask

  task automatic test_overflow;
    bit seen;
    int lat;
    run_pulse(3000, seen, lat);
    n_tests++; if (!seen || bus.width_o !== 15'd2000) begin n_fail++; $display("FAIL ovf_width: got %0d seen=%0d expected 2000", bus.width_o, seen); end
    n_tests++; if (bus.ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", bus.ovf_o); end
    n_tests++; if (bus.level_o !== 2'b10) begin n_fail++; $display("FAIL ovf_level: got %b expected 10", bus.level_o); end
    run_pulse(1999, seen, lat);
    n_tests++; if (bus.width_o !== 15'd1999 || bus.ovf_o !== 1'b0) begin n_fail++; $display("FAIL ovf_1999: got width %0d ovf %b expected 1999 0", bus.width_o, bus.ovf_o); end
    run_pulse(2000, seen, lat);
    n_tests++; if (bus.width_o !== 15'd2000 || bus.ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_2000: got width %0d ovf %b expected 2000 1", bus.width_o, bus.ovf_o); end
    run_pulse(1500, seen, lat);
    n_tests++; if (bus.ovf_o !== 1'b0 || bus.width_o !== 15'd1500) begin n_fail++; $display("FAIL ovf_clear: got ovf %b width %0d expected 0 1500", bus.ovf_o, bus.width_o); end
  endtask

  task automatic test_enable_high;
    bit seen;
    int lat;
    int s0;
    bus.en = 1'b0;
    repeat (10) @(negedge clk);
    bus.pwm_in = 1'b1;
    repeat (100) @(negedge clk);
    s0 = strobe_cnt;
    bus.en = 1'b1;
    repeat (500) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (50) @(negedge clk);
    n_tests++; if (strobe_cnt != s0) begin n_fail++; $display("FAIL en_high_nostrobe: got %0d strobes expected 0", strobe_cnt - s0); end
    n_tests++; if (bus.width_o !== 15'd1500) begin n_fail++; $display("FAIL en_high_hold: got %0d expected 1500", bus.width_o); end
    run_pulse(1200, seen, lat);
    n_tests++; if (!seen || bus.width_o !== 15'd1200 || bus.level_o !== 2'b01) begin n_fail++; $display("FAIL en_high_next: got width %0d level %b seen=%0d expected 1200 01", bus.width_o, bus.level_o, seen); end
  endtask

  task automatic test_glitch;
    bit seen;
    int lat;
    int s0;
    s0 = strobe_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.pwm_in = 1'b1;
      repeat (2) @(negedge clk);
      bus.pwm_in = 1'b0;
      repeat (10) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    n_tests++; if (strobe_cnt != s0) begin n_fail++; $display("FAIL glitch_nostrobe: got %0d strobes expected 0", strobe_cnt - s0); end
    n_tests++; if (bus.width_o !== 15'd1200) begin n_fail++; $display("FAIL glitch_hold: got %0d expected 1200", bus.width_o); end
    run_pulse(3, seen, lat);
    n_tests++; if (!seen || bus.width_o !== 15'd3 || bus.level_o !== 2'b00) begin n_fail++; $display("FAIL glitch_min_pulse: got width %0d level %b seen=%0d expected 3 00", bus.width_o, bus.level_o, seen); end
  endtask

  task automatic test_timeout;
    bit seen;
    int lat;
    run_pulse(1500, seen, lat);
    repeat (23000) @(negedge clk);
    n_tests++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", bus.timeout_o); end
    repeat (1000) @(negedge clk);
    n_tests++; if (bus.timeout_o !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b expected 1", bus.timeout_o); end
    @(negedge clk);
    bus.pwm_in = 1'b1;
    repeat (700) @(negedge clk);
    n_tests++; if (bus.timeout_o !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", bus.timeout_o); end
    repeat (800) @(negedge clk);
    bus.pwm_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.width_vld_o === 1'b1) seen = 1'b1;
    end
    n_tests++; if (!seen || bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got timeout %b seen=%0d expected 0 1", bus.timeout_o, seen); end
    n_tests++; if (bus.width_o !== 15'd1500) begin n_fail++; $display("FAIL timeout_width: got %0d expected 1500", bus.width_o); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_en_off;
    bit seen;
    int lat;
    int s0;
    s0 = strobe_cnt;
    @(negedge clk);
    bus.pwm_in = 1'b1;
    repeat (500) @(negedge clk);
    bus.en = 1'b0;
    repeat (500) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (19000) @(negedge clk);
    n_tests++; if (strobe_cnt != s0) begin n_fail++; $display("FAIL en_off_nostrobe: got %0d strobes expected 0", strobe_cnt - s0); end
    n_tests++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL en_off_timeout: got %b expected 0", bus.timeout_o); end
    n_tests++; if (bus.width_o !== 15'd1500 || bus.level_o !== 2'b01 || bus.ovf_o !== 1'b0) begin n_fail++; $display("FAIL en_off_hold: got width %0d level %b ovf %b expected 1500 01 0", bus.width_o, bus.level_o, bus.ovf_o); end
    bus.en = 1'b1;
    repeat (20) @(negedge clk);
    run_pulse(1950, seen, lat);
    n_tests++; if (!seen || bus.width_o !== 15'd1950 || bus.level_o !== 2'b10) begin n_fail++; $display("FAIL en_off_resume: got width %0d level %b seen=%0d expected 1950 10", bus.width_o, bus.level_o, seen); end
  endtask

  task automatic test_reset_mid_pulse;
    bit seen;
    int lat;
    int s0;
    @(negedge clk);
    bus.pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    s0 = strobe_cnt;
    repeat (700) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (40) @(negedge clk);
    n_tests++; if (strobe_cnt != s0) begin n_fail++; $display("FAIL rst_mid_nostrobe: got %0d strobes expected 0", strobe_cnt - s0); end
    n_tests++; if (bus.width_o !== 15'd0 || bus.level_o !== 2'b00) begin n_fail++; $display("FAIL rst_mid_cleared: got width %0d level %b expected 0 00", bus.width_o, bus.level_o); end
    run_pulse(1500, seen, lat);
    n_tests++; if (!seen || bus.width_o !== 15'd1500) begin n_fail++; $display("FAIL rst_mid_next: got width %0d seen=%0d expected 1500", bus.width_o, seen); end
  endtask

  task automatic test_back_to_back;
    int s0;
    s0 = strobe_cnt;
    @(negedge clk);
    bus.pwm_in = 1'b1;
    repeat (1200) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    bus.pwm_in = 1'b1;
    repeat (1300) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (40) @(negedge clk);
    n_tests++; if (strobe_cnt - s0 != 2) begin n_fail++; $display("FAIL b2b_count: got %0d strobes expected 2", strobe_cnt - s0); end
    n_tests++; if (bus.width_o !== 15'd1300) begin n_fail++; $display("FAIL b2b_width: got %0d expected 1300", bus.width_o); end
    n_tests++; if (consec_cnt != 0) begin n_fail++; $display("FAIL b2b_consecutive_vld: got %0d expected 0", consec_cnt); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.pwm_in = 1'b0;
    test_reset();
    test_basic();
    test_levels();
    test_overflow();
    test_enable_high();
    test_glitch();
    test_timeout();
    test_en_off();
    test_reset_mid_pulse();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
